// File: rtl/vel_mbox_pkg.sv
// vel_mbox_pkg: shared FSM states, default word format and record type for the velocity mailbox reader
package vel_mbox_pkg;
   localparam int DEF_W     = 16;
   localparam int DEF_FRAC  = 11;
   localparam int DEF_BOT_W = 2;
   typedef enum logic [1:0] {WAIT, SAMPLE, EMIT, ACK} vel_state_t;
   typedef struct packed {
      logic [DEF_BOT_W-1:0] bot;
      logic [DEF_W-1:0]     vx;
      logic [DEF_W-1:0]     vy;
      logic                 stale;
   } vel_rec_t;
endpackage

// File: rtl/vel_stale_timer.sv
// vel_stale_timer: per-bot cycles-since-last-update counter, saturating at TIMEOUT
module vel_stale_timer
#(
   parameter int TIMEOUT = 4096
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   assign o_expired = r_cnt == CW'(TIMEOUT);
   // count idle cycles, hold at the limit, restart on a consumed update
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else r_cnt <= i_clr ? '0 : o_expired ? r_cnt : r_cnt + 1'b1;
endmodule

// File: rtl/vel_mailbox_reader.sv
// vel_mailbox_reader: round-robin consumer of per-bot velocity mailboxes; VEL_TIMEOUT_EN adds zero-velocity stale records
module vel_mailbox_reader
   import vel_mbox_pkg::*;
#(
   parameter int NBOT     = 3,
   parameter int W        = DEF_W,
   parameter int FRAC     = DEF_FRAC,
   parameter int POLL_GAP = 100,
   parameter int TIMEOUT  = 4096
)(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NBOT-1:0]          i_mb_full,
   input  logic [NBOT*W-1:0]        i_mb_vx,
   input  logic [NBOT*W-1:0]        i_mb_vy,
   output logic [NBOT-1:0]          o_mb_ack,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [$clog2(NBOT)-1:0]  o_out_bot,
   output logic [W-1:0]             o_out_vx,
   output logic [W-1:0]             o_out_vy,
   output logic                     o_out_stale
);
   localparam int BW = $clog2(NBOT);
   localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;

   if (POLL_GAP < 1 || FRAC >= W || TIMEOUT < 1 || NBOT < 2) begin : g_bad_cfg
      $error("vel_mailbox_reader: unsupported parameter set");
   end

   vel_state_t    r_state, w_state_nxt;
   logic [BW-1:0] r_idx, w_idx_nxt, r_bot;
   logic [GW-1:0] r_gcnt;
   logic [W-1:0]  r_vx, r_vy;
   logic          w_hs, w_hit, w_take, w_adv;

   assign w_hs      = r_state == EMIT && i_out_ready;
   assign w_take    = i_mb_full[r_idx] || w_hit;
   assign w_adv     = (r_state == SAMPLE && !w_take) || (w_hs && o_out_stale) || r_state == ACK;
   assign w_idx_nxt = r_idx == BW'(NBOT - 1) ? '0 : r_idx + 1'b1;
   assign o_out_bot = r_bot;
   assign o_out_vx  = r_vx;
   assign o_out_vy  = r_vy;

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= WAIT;
      else r_state <= w_state_nxt;

   // next state: stale records return straight to WAIT, real ones go through ACK
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT:    w_state_nxt = r_gcnt == '0 ? SAMPLE : WAIT;
         SAMPLE:  w_state_nxt = w_take ? EMIT : WAIT;
         EMIT:    w_state_nxt = !w_hs ? EMIT : o_out_stale ? WAIT : ACK;
         default: w_state_nxt = WAIT;
      endcase
   end

   // outputs decoded from state; the ack targets the bot still held in idx
   always_comb begin
      o_out_valid = r_state == EMIT;
      o_mb_ack    = r_state == ACK ? NBOT'(1) << r_idx : '0;
   end

   // gap counter, poll index and the latched record
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_gcnt <= GW'(POLL_GAP - 1);
         r_idx  <= '0;
         r_bot  <= '0;
         r_vx   <= '0;
         r_vy   <= '0;
      end else begin
         r_gcnt <= w_adv ? GW'(POLL_GAP - 1) : (r_state == WAIT && r_gcnt != '0) ? r_gcnt - 1'b1 : r_gcnt;
         r_idx  <= w_adv ? w_idx_nxt : r_idx;
         if (r_state == SAMPLE && w_take) begin
            r_bot <= r_idx;
            r_vx  <= i_mb_full[r_idx] ? i_mb_vx[r_idx*W +: W] : '0;
            r_vy  <= i_mb_full[r_idx] ? i_mb_vy[r_idx*W +: W] : '0;
         end
      end

`ifdef VEL_TIMEOUT_EN
   logic [NBOT-1:0] w_expired, w_clr;
   logic            r_stale;
   genvar g;
   for (g = 0; g < NBOT; g++) begin : g_timer
      assign w_clr[g] = r_idx == BW'(g) && (r_state == ACK || (w_hs && r_stale));
      vel_stale_timer #(.TIMEOUT(TIMEOUT)) u_timer (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_clr     (w_clr[g]),
         .o_expired (w_expired[g])
      );
   end
   assign w_hit       = !i_mb_full[r_idx] && w_expired[r_idx];
   assign o_out_stale = r_stale;
   // stale marker is latched alongside the record it describes
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_stale <= 1'b0;
      else r_stale <= (r_state == SAMPLE && w_take) ? w_hit : r_stale;
`else
   assign w_hit       = 1'b0;
   assign o_out_stale = 1'b0;
`endif
endmodule
